// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end for the sequence detector.
// Words arrive over a valid/ready handshake and leave as one bit per clock
// on serial_out. A single holding buffer lets a second word queue up
// behind the one being shifted, so consecutive words run with no idle gap.
module bit_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_start,
    output logic             busy,
    output logic [15:0]      word_count
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Registered state
    state_t           state_q;
    logic [WIDTH-1:0] shifter_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [WIDTH-1:0] buf_q;
    logic             buf_full_q;

    // Next-state values
    state_t           state_d;
    logic [WIDTH-1:0] shifter_d;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [WIDTH-1:0] buf_d;
    logic             buf_full_d;
    logic [15:0]      word_count_d;

    logic             transfer;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    // Ready depends only on the buffer flag, so there is no combinational
    // path from word_valid back to word_ready.
    assign word_ready = !buf_full_q;
    assign transfer   = word_valid && word_ready;
    assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign shifted    = MSB_FIRST ? (shifter_q << 1) : (shifter_q >> 1);

    // Next-state and datapath update for the IDLE/SHIFT controller.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        shifter_d    = shifter_q;
        bit_cnt_d    = bit_cnt_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        word_count_d = word_count;

        case (state_q)
            IDLE: begin
                // The buffer is always empty here, so a transfer goes
                // straight to the shifter and the first bit follows next cycle.
                if (transfer) begin
                    shifter_d = word_in;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (last_bit) begin
                    word_count_d = word_count + 16'd1;
                    bit_cnt_d    = '0;
                    if (buf_full_q) begin
                        // Queued word follows immediately; ready was low this
                        // cycle, so no new transfer can collide with the move.
                        shifter_d  = buf_q;
                        buf_full_d = 1'b0;
                    end else if (transfer) begin
                        // Word offered on the final bit bypasses the buffer.
                        shifter_d = word_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shifter_d = shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (transfer) begin
                        buf_d      = word_in;
                        buf_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            shifter_q  <= '0;
            bit_cnt_q  <= '0;
            // NOTE: the buffer data is cleared along with its flag so a stale word can never reappear after reset.
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            word_count <= '0;
        end else begin
            state_q    <= state_d;
            shifter_q  <= shifter_d;
            bit_cnt_q  <= bit_cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            word_count <= word_count_d;
        end
    end

    // Output decode straight from registered state.
    assign serial_valid = (state_q == SHIFT);
    assign serial_out   = serial_valid
                          ? (MSB_FIRST ? shifter_q[WIDTH-1] : shifter_q[0])
                          : IDLE_BIT;
    assign word_start   = serial_valid && (bit_cnt_q == '0);
    assign busy         = serial_valid || buf_full_q;

endmodule
